// File: rtl/splitflap_pkg.sv
// Shared types and defaults for the LED frame receive path that feeds the mux core.
package splitflap_pkg;

   localparam int FRAME_BITS_DEFAULT  = 128;
   localparam int SYNC_STAGES_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      OVERRUN = 2'd2
   } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise and fall pulses derived from the synchronized level.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // prev_q holds last cycle's synchronized level so the edge pulses are exactly one cycle wide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// Receives a fixed-length LED frame over sck/sdi/load and commits it to
// `matrix` atomically, only when exactly FRAME_BITS bits were clocked in.
module spi_frame_rx
   import splitflap_pkg::*;
#(
   parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  sdi,
   input  logic                  load,
   output logic [FRAME_BITS-1:0] matrix,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic                  busy,
   output logic [7:0]            frame_count
);

   localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FRAME_BITS);

   logic sck_s, sck_rise, sck_fall_unused;
   logic load_s, load_rise_unused, load_fall_unused;
   logic sdi_s, sdi_rise_unused, sdi_fall_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .clk    (clk),
      .reset  (reset),
      .d_i    (sck),
      .level_o(sck_s),
      .rise_o (sck_rise),
      .fall_o (sck_fall_unused)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
      .clk    (clk),
      .reset  (reset),
      .d_i    (load),
      .level_o(load_s),
      .rise_o (load_rise_unused),
      .fall_o (load_fall_unused)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk    (clk),
      .reset  (reset),
      .d_i    (sdi),
      .level_o(sdi_s),
      .rise_o (sdi_rise_unused),
      .fall_o (sdi_fall_unused)
   );

   rx_state_t             state_q;
   logic [FRAME_BITS-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] matrix_q;
   logic                  frame_valid_q, frame_err_q, busy_q;
   logic [7:0]            frame_count_q;

   assign shadow_d  = {shadow_q[FRAME_BITS-2:0], sdi_s};
   assign bit_cnt_d = bit_cnt_q + CNT_W'(1);

   // The load_s level alone decides frame end, so an sck edge racing the fall never shifts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         shadow_q      <= '0;
         bit_cnt_q     <= '0;
         matrix_q      <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (load_s) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            SHIFT: begin
               if (!load_s) begin
                  if (bit_cnt_q == FULL_CNT) begin
                     matrix_q      <= shadow_q;
                     frame_valid_q <= 1'b1;
                     frame_count_q <= frame_count_q + 8'd1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (sck_rise) begin
                  if (bit_cnt_q < FULL_CNT) begin
                     shadow_q  <= shadow_d;
                     bit_cnt_q <= bit_cnt_d;
                  end else begin
                     state_q <= OVERRUN;
                  end
               end
            end
            OVERRUN: begin
               if (!load_s) begin
                  frame_err_q <= 1'b1;
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign matrix      = matrix_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign busy        = busy_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: table vectors, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_spi_frame_rx;
   import splitflap_pkg::*;

   localparam int FB       = 128;
   localparam int SMALL_FB = 8;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic          sck   = 1'b0;
   logic          sdi   = 1'b0;
   logic          load  = 1'b0;
   logic [FB-1:0] matrix;
   logic          frameValid, frameErr, busy;
   logic [7:0]    frameCount;

   logic                sck2  = 1'b0;
   logic                sdi2  = 1'b0;
   logic                load2 = 1'b0;
   logic [SMALL_FB-1:0] matrix2;
   logic                frameValid2, frameErr2, busy2;
   logic [7:0]          frameCount2;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [FB-1:0] expMatrix   = '0;
   logic [7:0]    expCount    = 8'd0;

   typedef struct {
      logic [FB-1:0] data;
      int            nbits;
      bit            race;
      int            half;
      bit            expCommit;
      string         name;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .sck        (sck),
      .sdi        (sdi),
      .load       (load),
      .matrix     (matrix),
      .frame_valid(frameValid),
      .frame_err  (frameErr),
      .busy       (busy),
      .frame_count(frameCount)
   );

   // Narrow instance so the 8-bit frame counter can be wrapped in a short run.
   spi_frame_rx #(.FRAME_BITS(SMALL_FB), .SYNC_STAGES(2)) dutSmall (
      .clk        (clk),
      .reset      (reset),
      .sck        (sck2),
      .sdi        (sdi2),
      .load       (load2),
      .matrix     (matrix2),
      .frame_valid(frameValid2),
      .frame_err  (frameErr2),
      .busy       (busy2),
      .frame_count(frameCount2)
   );

   // The two result pulses must never coincide on either instance.
   always @(negedge clk) begin
      if ((frameValid && frameErr) || (frameValid2 && frameErr2)) begin
         miscompares++;
         $display("[TB] FAIL pulse_exclusive: valid and err both high at %0t", $time);
      end
   end

   task automatic checkOutput(input string name, input logic [FB-1:0] actual,
                              input logic [FB-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Reference rule: a frame commits only if exactly FB bits arrived while load was high.
   function automatic bit modelCommits(input int nbits);
      return nbits == FB;
   endfunction

   task automatic shiftBit(input logic b, input int half);
      sdi = b;
      repeat (half) @(negedge clk);
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic startFrame(input logic [FB-1:0] data, input int nbits, input int half,
                             input string name);
      load = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checkOutput({name, "_busy_rise"}, FB'(busy), FB'(c >= 3));
      end
      for (int i = 0; i < nbits; i++) begin
         if (i < FB) shiftBit(data[FB-1-i], half);
         else        shiftBit(1'b1, half);
      end
   endtask

   task automatic finishFrame(input logic [FB-1:0] data, input bit race, input int half,
                              input bit expCommit, input string name);
      logic [FB-1:0] oldMatrix;
      oldMatrix = expMatrix;
      if (race) begin
         repeat (half) @(negedge clk);
         sdi  = 1'($urandom);
         sck  = 1'b1;
         load = 1'b0;
      end else begin
         repeat (2) @(negedge clk);
         load = 1'b0;
      end
      if (expCommit) begin
         expMatrix = data;
         expCount  = expCount + 8'd1;
      end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c < 3) begin
            checkOutput({name, "_early_pulse"}, FB'({frameValid, frameErr}), '0);
            checkOutput({name, "_early_matrix"}, matrix, oldMatrix);
         end
      end
      checkOutput({name, "_valid"}, FB'(frameValid), FB'(expCommit));
      checkOutput({name, "_err"}, FB'(frameErr), FB'(!expCommit));
      checkOutput({name, "_matrix"}, matrix, expMatrix);
      checkOutput({name, "_count"}, FB'(frameCount), FB'(expCount));
      checkOutput({name, "_busy_fall"}, FB'(busy), '0);
      @(negedge clk);
      sck = 1'b0;
      checkOutput({name, "_pulse_width"}, FB'({frameValid, frameErr}), '0);
      repeat (3) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [FB-1:0] data, input int nbits, input bit race,
                                input int half, input bit expCommit, input string name);
      startFrame(data, nbits, half, name);
      finishFrame(data, race, half, expCommit, name);
   endtask

   task automatic sendSmall(input logic [SMALL_FB-1:0] d);
      load2 = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = SMALL_FB - 1; i >= 0; i--) begin
         sdi2 = d[i];
         repeat (3) @(negedge clk);
         sck2 = 1'b1;
         repeat (3) @(negedge clk);
         sck2 = 1'b0;
      end
      repeat (2) @(negedge clk);
      load2 = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      logic [FB-1:0] rdata;
      int            rbits;
      bit            rrace;
      logic [7:0]    expCount2;

      vecs[0] = '{128'hFF00_AA55_0F0F_F0F0_8001_7FFE_C3C3_3C3C, 128, 1'b0, 4, 1'b1, "good"};
      vecs[1] = '{128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128, 1'b0, 3, 1'b1, "commit1234"};
      vecs[2] = '{128'hA5A5_5A5A_F00F_0FF0_1111_2222_3333_4444, 127, 1'b0, 3, 1'b0, "short127"};
      vecs[3] = '{128'h0, 0, 1'b0, 3, 1'b0, "zero_bits"};
      vecs[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 1, 1'b0, 3, 1'b0, "one_bit"};
      vecs[5] = '{128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 128, 1'b1, 3, 1'b1, "edge_race"};
      vecs[6] = '{128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 128, 1'b0, 3, 1'b1, "good_lsb"};

      repeat (3) @(negedge clk);
      checkOutput("reset_matrix", matrix, '0);
      checkOutput("reset_pulses", FB'({frameValid, frameErr}), '0);
      checkOutput("reset_busy", FB'(busy), '0);
      checkOutput("reset_count", FB'(frameCount), '0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].data, vecs[v].nbits, vecs[v].race, vecs[v].half,
                       vecs[v].expCommit, vecs[v].name);
      end

      startFrame(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 129, 3, "overrun");
      repeat (4) @(negedge clk);
      checkOutput("overrun_state", FB'(dut.state_q), FB'(OVERRUN));
      checkOutput("overrun_busy", FB'(busy), FB'(1'b1));
      finishFrame(128'h0, 1'b0, 3, 1'b0, "overrun");

      startFrame(128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 64, 3, "midreset");
      reset = 1'b0;
      #1;
      checkOutput("midreset_matrix", matrix, '0);
      checkOutput("midreset_pulses", FB'({frameValid, frameErr}), '0);
      checkOutput("midreset_busy", FB'(busy), '0);
      checkOutput("midreset_count", FB'(frameCount), '0);
      expMatrix = '0;
      expCount  = 8'd0;
      load      = 1'b0;
      sdi       = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("post_reset_matrix_hold", matrix, '0);
      applyStimulus({FB{1'b1}}, 128, 1'b0, 3, 1'b1, "all_ones");

      for (int r = 0; r < 16; r++) begin
         rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
         if ($urandom_range(0, 2) != 0) rbits = FB;
         else                           rbits = int'($urandom_range(0, FB + 6));
         rrace = ($urandom_range(0, 3) == 0);
         applyStimulus(rdata, rbits, rrace, 3, modelCommits(rbits), "random");
      end

      expCount2 = 8'd0;
      for (int f = 1; f <= 257; f++) begin
         logic [SMALL_FB-1:0] d;
         d = SMALL_FB'($urandom);
         sendSmall(d);
         expCount2 = expCount2 + 8'd1;
         checkOutput("wrap_count", FB'(frameCount2), FB'(expCount2));
         checkOutput("wrap_matrix", FB'(matrix2), FB'(d));
      end
      checkOutput("wrap_final_count", FB'(frameCount2), FB'(8'd1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Receives a 128-bit LED frame over a 3-wire SPI-style link (sck, sdi, load) and delivers it, fully synchronized to the system clock, to the LED multiplexing core as a glitch-free `matrix` word. It sits directly upstream of the LED mux core. All SPI inputs are synchronized into `clk` and the frame is length-checked. `matrix` updates only in one clock cycle after a frame of exactly the right length has been received, so the display never shows a partially shifted frame.

## Interface
- `FRAME_BITS`, default 128: frame length in bits. The upper 64 bits drive the X matrix; the lower 64 bits drive the Y matrix.
- `SYNC_STAGES`, default 2: number of synchronizer flops on each SPI input (minimum 2).
- `clk`  in  1: system clock (the internal oscillator domain).
- `reset`  in  1: asynchronous, active-low reset.
- `sck`  in  1: SPI clock, asynchronous to `clk`. Data is sampled on its rising edge.
- `sdi`  in  1: SPI data, MSB first.
- `load`  in  1: frame enable, active-high, asynchronous. It is high for the whole frame.
- `matrix`  out  FRAME_BITS: last committed frame.
- `frame_valid`  out  1: one-cycle pulse, high in the first cycle in which `matrix` shows a new frame.
- `frame_err`  out  1: one-cycle pulse when a frame is rejected (too short or too long).
- `busy`  out  1: high while a frame is being received (state is not IDLE).
- `frame_count`  out  8: number of committed frames, modulo 256.

## Operation
- Synchronization:
  - `sck`, `sdi` and `load` each pass through SYNC_STAGES flops, giving `sck_s`, `sdi_s` and `load_s`.
  - `sck_rise` = `sck_s` & ~previous `sck_s`.
- Shadow register and counter:
  - Shadow register `shadow[FRAME_BITS-1:0]`.
  - Bit counter `bit_cnt`, width $clog2(FRAME_BITS+1), saturating at FRAME_BITS.
- State IDLE:
  - When `load_s`=1, go to SHIFT and clear `bit_cnt` to 0.
  - `sck_rise` in that same cycle is ignored.
- State SHIFT, with `load_s`=1 and `sck_rise`:
  - If `bit_cnt` < FRAME_BITS: `shadow` <= {`shadow`[FRAME_BITS-2:0], `sdi_s`} and `bit_cnt`++.
  - If `bit_cnt` = FRAME_BITS: go to OVERRUN and leave `shadow` unchanged.
- State SHIFT, with `load_s`=0:
  - Any `sck_rise` in this cycle is ignored.
  - If `bit_cnt` = FRAME_BITS: `matrix` <= `shadow`, `frame_valid` <= 1, `frame_count`++ (wraps 255 to 0).
  - Otherwise: `frame_err` <= 1 and `matrix` is unchanged.
  - In both cases go to IDLE.
- State OVERRUN:
  - All `sck_rise` events are ignored.
  - When `load_s`=0: `frame_err` <= 1, `matrix` is unchanged, go to IDLE.
- `frame_valid` and `frame_err` are registered and never high in the same cycle.
- The `shadow` contents are don't-care outside SHIFT. `shadow` is not cleared between frames.
- A frame with 0 bits (load pulse without any sck) is rejected with `frame_err`.
- Reset, including mid-frame: state = IDLE, and the following are all 0: `matrix`, `frame_valid`, `frame_err`, `busy`, `frame_count`, `bit_cnt`, `shadow`, all synchronizer flops.

## Timing
- Input constraints:
  - The `sck` high and low phases are each at least 2 `clk` periods, plus SYNC_STAGES jitter margin. Equivalently, f_sck ≤ f_clk/4.
  - `sdi` is stable from at least 1 `clk` period before the `sck` rising edge until 1 period after it.
  - `load` falls no earlier than 2 `clk` periods after the last `sck` rising edge.
  - `load` stays low for at least 2 `clk` periods between frames.
- Latency, commit: a `load` fall is first captured at clk edge k. `matrix` and `frame_valid` change at edge k+SYNC_STAGES, i.e. 2 edges for the default.
- Latency, error: `frame_err` follows the same timing as the commit path.
- `busy` rises SYNC_STAGES+1 edges after `load` rises.
- `matrix` holds its value across reset release until the first valid commit.
- `matrix` is never partially updated: all bits change in the same cycle.

## Structure
- Package `splitflap_pkg`:
  - `localparam FRAME_BITS_DEFAULT = 128`.
  - `typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} rx_state_t`.
- Sub-module `sync_edge`, parameterized on SYNC_STAGES, with the same `clk` and `reset`:
  - Outputs: synchronized level, one-cycle `rise` pulse, one-cycle `fall` pulse.
  - Instantiated for `sck` and `load`. `sdi` uses only its level output.
- The top level holds the FSM, `shadow`, `bit_cnt`, `matrix` and `frame_count`.

## Test plan
- Good frame:
  - Stimulus: shift 128 bits 0xFF00_AA55_0F0F_F0F0_8001_7FFE_C3C3_3C3C at f_clk/8, then drop `load`.
  - Required: `matrix` equals that value 2 edges after the fall, `frame_valid` pulses for exactly 1 cycle, `frame_count`=1, `frame_err` never asserts.
- Short frame:
  - Stimulus: commit 0x1234...(128 bits), then shift 127 bits.
  - Required: `frame_err` pulses once, `matrix` still equals the first frame, `frame_count` unchanged.
- Overrun:
  - Stimulus: shift 129 bits.
  - Required: state reaches OVERRUN after bit 129, `frame_err` pulses on the `load` fall, `matrix` unchanged.
- Reset mid-frame:
  - Stimulus: assert `reset`=0 after bit 64, release it, then send a good 128-bit frame of all ones.
  - Required: all outputs are 0 during reset, then `matrix`=all ones, `frame_count`=1.
- Counter wrap:
  - Stimulus: send 256 good frames, then 1 more.
  - Required: `frame_count` reads 0 after frame 256 and 1 after frame 257.
- Edge race:
  - Stimulus: an `sck` rising edge arrives in the same synchronized cycle as the `load` fall, after 128 valid bits.
  - Required: the edge is ignored, the frame commits, `matrix` equals the 128 bits that preceded it.
